// File: rtl/alu_result_stage_pkg.sv
// ----------------------------------------------------------------------------
// alu_result_stage_pkg
//   Shared definitions for the ALU result stage:
//     - op encodings driven by the issue logic on in_op
//     - the flag bundle stored alongside every buffered result
//     - FLAGS_W, the flag bundle width (a FIFO entry is WIDTH + FLAGS_W bits)
// ----------------------------------------------------------------------------
package alu_result_stage_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    // Encodings 4..7 are illegal; they produce a zero result with op_err set.

    typedef struct packed {
        logic zero;    // selected result == 0
        logic neg;     // selected result MSB
        logic carry;   // adder carry-out, ADD only
        logic op_err;  // entry came from an illegal op
    } flags_t;

    localparam int FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/alu_result_stage_if.sv
// ----------------------------------------------------------------------------
// alu_result_stage_if
//   Bundles both sides of the result stage.
//   Handshake rule, identical on both sides: a transfer happens on a rising
//   clock edge where valid and ready are both high; the sender holds its
//   payload stable while valid is high and ready is low.
//
//   Upstream side : in_valid, in_ready, in_op, and_res, or_res, xor_res, add_res
//   Writeback side: out_valid, out_ready, out_result, out_zero, out_neg,
//                   out_carry, out_op_err
//
//   modport slave  : the result stage itself
//   modport master : the environment (issue logic + writeback consumer)
// ----------------------------------------------------------------------------
interface alu_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] or_res;
    logic [WIDTH-1:0] xor_res;
    logic [WIDTH:0]   add_res;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_op_err;

    modport slave (
        input  in_valid, in_op, and_res, or_res, xor_res, add_res, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_neg, out_carry,
               out_op_err
    );

    modport master (
        output in_valid, in_op, and_res, or_res, xor_res, add_res, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry,
               out_op_err
    );

endinterface

// File: rtl/alu_result_stage_result_fifo.sv
// ----------------------------------------------------------------------------
// alu_result_stage_result_fifo
//   Generic DEPTH x W synchronous FIFO with registered occupancy count.
//   Ports:
//     clk, rst_n : clock, async active-low reset (clears pointers, count, data)
//     push       : write wr_data this edge (ignored while full)
//     wr_data    : entry to write
//     pop        : drop the head entry this edge (ignored while empty)
//     rd_data    : head entry (valid only when !empty)
//     count      : number of stored entries, 0..DEPTH
//     full/empty : decoded from count only, never from push/pop
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module alu_result_stage_result_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle does not make room: full blocks the push.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ----------------------------------------------------------------------------
// alu_result_stage
//   Registered result stage behind the 32-bit logic/arith units. Each accepted
//   op selects one unit output, derives zero/neg/carry/op_err flags, and the
//   {result, flags} entry is buffered in a small FIFO that feeds writeback.
//   Nothing passes combinationally from the upstream side to the out_* side;
//   an entry pushed into an empty FIFO appears one cycle later.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : async active-low reset; discards all buffered entries
//     bus       : alu_result_stage_if.slave (upstream + writeback handshakes)
//     dbg_count : registered FIFO occupancy, for observation only
// ----------------------------------------------------------------------------
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_stage_if.slave        bus,
    output logic [$clog2(DEPTH):0]   dbg_count
);

    localparam int EW = WIDTH + FLAGS_W;

    logic [WIDTH-1:0] sel;
    flags_t           sel_flags;
    logic [EW-1:0]    head;
    logic [WIDTH-1:0] head_result;
    flags_t           head_flags;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Unit select and flag generation for the op being offered upstream.
    always_comb begin
        sel       = '0;
        sel_flags = '0;
        case (bus.in_op)
            OP_AND: sel = bus.and_res;
            OP_OR:  sel = bus.or_res;
            OP_XOR: sel = bus.xor_res;
            OP_ADD: begin
                sel             = bus.add_res[WIDTH-1:0];
                sel_flags.carry = bus.add_res[WIDTH];
            end
            default: sel_flags.op_err = 1'b1;
        endcase
        sel_flags.zero = (sel == '0);
        sel_flags.neg  = sel[WIDTH-1];
    end

    // in_ready comes from registered count only, so it has no path from
    // out_ready or in_valid.
    assign bus.in_ready = ~full;
    assign push         = bus.in_valid & ~full;
    assign pop          = bus.out_valid & bus.out_ready;

    alu_result_stage_result_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({sel, sel_flags}),
        .pop     (pop),
        .rd_data (head),
        .count   (dbg_count),
        .full    (full),
        .empty   (empty)
    );

    assign head_result = head[EW-1:FLAGS_W];
    assign head_flags  = flags_t'(head[FLAGS_W-1:0]);

    // Outputs are forced to zero whenever no entry is presented, so stale
    // storage contents never leak to the consumer.
    assign bus.out_valid  = ~empty;
    assign bus.out_result = bus.out_valid ? head_result       : '0;
    assign bus.out_zero   = bus.out_valid & head_flags.zero;
    assign bus.out_neg    = bus.out_valid & head_flags.neg;
    assign bus.out_carry  = bus.out_valid & head_flags.carry;
    assign bus.out_op_err = bus.out_valid & head_flags.op_err;

endmodule
